// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing for the five-stage MIPS datapath.
// Decides each cycle between advance, stall-with-bubble and IF/ID flush,
// starts the multi-cycle MDU and freezes the front end while it runs, and
// counts stall and flush cycles for performance measurement.
module hazard_stall_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [4:0]           IF_ID_rs,
    input  logic [4:0]           IF_ID_rt,
    input  logic                 ID_UsesRt,
    input  logic                 ID_Branch,
    input  logic                 ID_BranchTaken,
    input  logic                 ID_Jump,
    input  logic                 ID_MduOp,
    input  logic                 ID_EX_MemRead,
    input  logic                 ID_EX_RegWrite,
    input  logic [4:0]           ID_EX_Dest,
    input  logic                 EX_MEM_MemRead,
    input  logic [4:0]           EX_MEM_Dest,
    output logic                 PCWrite,
    output logic                 IF_ID_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Bubble,
    output logic                 Mdu_Start,
    output logic                 Mdu_Busy,
    output logic [CNT_WIDTH-1:0] Stall_Count,
    output logic [CNT_WIDTH-1:0] Flush_Count
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    // Wait counter is loaded with latency-1 so that counting down to zero
    // inclusive spans exactly MDU_LATENCY cycles.
    localparam logic [7:0] WAIT_LOAD = 8'(MDU_LATENCY - 1);

    state_t               state_q, state_d;
    logic [7:0]           waitCnt_q, waitCnt_d;
    logic [CNT_WIDTH-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_WIDTH-1:0] flushCnt_q, flushCnt_d;

    logic exMatch;
    logic memMatch;
    logic loadUse;
    logic branchOnEx;
    logic branchOnMem;
    logic hazardStall;
    logic redirect;

    // Register 0 is hardwired to zero, so a zero destination never creates a dependency;
    // rt only counts as a source when the ID instruction actually reads it.
    assign exMatch  = (ID_EX_Dest != 5'd0) &&
                      ((ID_EX_Dest == IF_ID_rs) || (ID_UsesRt && (ID_EX_Dest == IF_ID_rt)));
    assign memMatch = (EX_MEM_Dest != 5'd0) &&
                      ((EX_MEM_Dest == IF_ID_rs) || (ID_UsesRt && (EX_MEM_Dest == IF_ID_rt)));

    // A branch behind an EX load first stalls on branchOnEx, then on branchOnMem
    // once the load reaches MEM, giving the two-cycle penalty without extra state.
    assign loadUse     = ID_EX_MemRead && exMatch;
    assign branchOnEx  = ID_Branch && ID_EX_RegWrite && exMatch;
    assign branchOnMem = ID_Branch && EX_MEM_MemRead && memMatch;
    assign hazardStall = loadUse || branchOnEx || branchOnMem;
    assign redirect    = (ID_Branch && ID_BranchTaken) || ID_Jump;

    // Control outputs and next state, combinational from state and ID/EX/MEM inputs.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Mdu_Start    = 1'b0;
        Mdu_Busy     = 1'b0;
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;

        case (state_q)
            RUN: begin
                if (hazardStall) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                end else begin
                    if (redirect) begin
                        IF_ID_Flush = 1'b1;
                    end
                    if (ID_MduOp) begin
                        Mdu_Start = 1'b1;
                        state_d   = MDU_WAIT;
                        waitCnt_d = WAIT_LOAD;
                    end
                end
            end
            MDU_WAIT: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
                Mdu_Busy     = 1'b1;
                if (waitCnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    waitCnt_d = waitCnt_q - 8'd1;
                end
            end
        endcase

        // While reset is held the pipeline is left free-running with no side effects.
        if (!Rst_n) begin
            PCWrite      = 1'b1;
            IF_ID_Write  = 1'b1;
            IF_ID_Flush  = 1'b0;
            ID_EX_Bubble = 1'b0;
            Mdu_Start    = 1'b0;
            Mdu_Busy     = 1'b0;
        end
    end

    // Event counters advance on every cycle the PC is held or IF/ID is flushed, wrapping freely.
    always_comb begin
        stallCnt_d = stallCnt_q + (PCWrite ? '0 : CNT_WIDTH'(1));
        flushCnt_d = flushCnt_q + (IF_ID_Flush ? CNT_WIDTH'(1) : '0);
    end

    // State, wait counter and event counters; reset can abort an MDU wait at any time.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= RUN;
            waitCnt_q  <= 8'd0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign Stall_Count = stallCnt_q;
    assign Flush_Count = flushCnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic against a behavioural model of the pipeline controller.
module tb_hazard_stall_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 4;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       br;
        logic       taken;
        logic       jump;
        logic       mdu;
        logic       exMr;
        logic       exRw;
        logic [4:0] exDest;
        logic       memMr;
        logic [4:0] memDest;
    } stim_t;

    typedef struct packed {
        stim_t      in;
        logic [5:0] exp;
    } vec_t;

    // ctrl vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Mdu_Start, Mdu_Busy}
    localparam logic [5:0] C_ADV   = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b000100;
    localparam logic [5:0] C_FLUSH = 6'b111000;
    localparam logic [5:0] C_START = 6'b110010;
    localparam logic [5:0] C_WAIT  = 6'b000101;

    logic          Clk;
    logic          Rst_n;
    logic [4:0]    IF_ID_rs, IF_ID_rt, ID_EX_Dest, EX_MEM_Dest;
    logic          ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump, ID_MduOp;
    logic          ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead;
    logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Mdu_Start, Mdu_Busy;
    logic [CW-1:0] Stall_Count, Flush_Count;
    logic          pc1, ifw1, fl1, bub1, st1, busy1;
    logic [CW-1:0] stall1, flush1;

    int    total = 0;
    int    bad   = 0;
    int    mdlWait;
    int    mdlStall;
    int    mdlFlush;
    stim_t curStim;
    stim_t idle;
    stim_t s;
    vec_t  table_v[14];

    hazard_stall_ctrl #(.MDU_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
        .ID_MduOp(ID_MduOp), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_Dest(ID_EX_Dest), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_Dest(EX_MEM_Dest),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .Mdu_Start(Mdu_Start), .Mdu_Busy(Mdu_Busy),
        .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    hazard_stall_ctrl #(.MDU_LATENCY(1), .CNT_WIDTH(CW)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
        .ID_MduOp(ID_MduOp), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_Dest(ID_EX_Dest), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_Dest(EX_MEM_Dest),
        .PCWrite(pc1), .IF_ID_Write(ifw1), .IF_ID_Flush(fl1),
        .ID_EX_Bubble(bub1), .Mdu_Start(st1), .Mdu_Busy(busy1),
        .Stall_Count(stall1), .Flush_Count(flush1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [5:0] ctrlOf();
        return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Mdu_Start, Mdu_Busy};
    endfunction

    function automatic logic [5:0] ctrl1Of();
        return {pc1, ifw1, fl1, bub1, st1, busy1};
    endfunction

    function automatic logic depends(input logic [4:0] dest, input stim_t t);
        if (dest == 5'd0) return 1'b0;
        if (dest == t.rs) return 1'b1;
        return t.usesRt && (dest == t.rt);
    endfunction

    // Behavioural reference: while MDU cycles remain the front end is frozen,
    // otherwise the hazard rules decide between stall, redirect and MDU issue.
    function automatic logic [5:0] modelCtrl(input stim_t t);
        logic stallNow;
        if (mdlWait > 0) return C_WAIT;
        stallNow = (t.exMr && depends(t.exDest, t)) ||
                   (t.br && t.exRw && depends(t.exDest, t)) ||
                   (t.br && t.memMr && depends(t.memDest, t));
        if (stallNow) return C_STALL;
        if ((t.br && t.taken) || t.jump) return C_FLUSH;
        if (t.mdu) return C_START;
        return C_ADV;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t t);
        @(negedge Clk);
        curStim        = t;
        IF_ID_rs       = t.rs;
        IF_ID_rt       = t.rt;
        ID_UsesRt      = t.usesRt;
        ID_Branch      = t.br;
        ID_BranchTaken = t.taken;
        ID_Jump        = t.jump;
        ID_MduOp       = t.mdu;
        ID_EX_MemRead  = t.exMr;
        ID_EX_RegWrite = t.exRw;
        ID_EX_Dest     = t.exDest;
        EX_MEM_MemRead = t.memMr;
        EX_MEM_Dest    = t.memDest;
        #1;
    endtask

    // Advance one clock, update the model from the cycle just completed and compare counters.
    task automatic clockEdge();
        logic [5:0] e;
        logic [3:0] es, ef;
        e = modelCtrl(curStim);
        @(posedge Clk);
        if (!e[5]) mdlStall++;
        if (e[3])  mdlFlush++;
        if (mdlWait > 0) mdlWait--;
        else if (e[1]) mdlWait = LAT;
        #1;
        es = 4'(mdlStall);
        ef = 4'(mdlFlush);
        checkOutput("stallCount", 32'(Stall_Count), 32'(es));
        checkOutput("flushCount", 32'(Flush_Count), 32'(ef));
    endtask

    task automatic cycle(input stim_t t, input string name);
        applyStimulus(t);
        checkOutput(name, 32'(ctrlOf()), 32'(modelCtrl(t)));
        clockEdge();
    endtask

    // Assert reset with a load-use hazard present; outputs must still show a free-running pipe.
    task automatic doReset();
        stim_t h;
        h = idle;
        h.rs = 5'd7; h.exMr = 1'b1; h.exDest = 5'd7;
        applyStimulus(h);
        Rst_n = 1'b0;
        #1;
        checkOutput("resetCtrl", 32'(ctrlOf()), 32'(C_ADV));
        checkOutput("resetStall", 32'(Stall_Count), 32'd0);
        checkOutput("resetFlush", 32'(Flush_Count), 32'd0);
        checkOutput("resetCtrl1", 32'(ctrl1Of()), 32'(C_ADV));
        mdlWait = 0; mdlStall = 0; mdlFlush = 0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic br, input logic taken, input logic jump,
                                 input logic exMr, input logic exRw, input logic [4:0] exDest,
                                 input logic memMr, input logic [4:0] memDest);
        stim_t t;
        t.rs = rs; t.rt = rt; t.usesRt = usesRt; t.br = br; t.taken = taken; t.jump = jump;
        t.mdu = 1'b0; t.exMr = exMr; t.exRw = exRw; t.exDest = exDest;
        t.memMr = memMr; t.memDest = memDest;
        return t;
    endfunction

    initial begin
        idle = mk(5'd1, 5'd2, 1'b1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0);
        mdlWait = 0; mdlStall = 0; mdlFlush = 0;
        Rst_n = 1'b0;
        curStim = idle;
        IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; ID_UsesRt = 1'b0; ID_Branch = 1'b0;
        ID_BranchTaken = 1'b0; ID_Jump = 1'b0; ID_MduOp = 1'b0; ID_EX_MemRead = 1'b0;
        ID_EX_RegWrite = 1'b0; ID_EX_Dest = 5'd0; EX_MEM_MemRead = 1'b0; EX_MEM_Dest = 5'd0;

        //                   rs     rt     uRt br tk jp exMr exRw exDest memMr memDest
        table_v[0]  = '{mk(5'd1, 5'd2, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0), C_ADV};
        table_v[1]  = '{mk(5'd2, 5'd9, 1, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0), C_STALL};
        table_v[2]  = '{mk(5'd1, 5'd5, 1, 0, 0, 0, 1, 1, 5'd5, 0, 5'd0), C_STALL};
        table_v[3]  = '{mk(5'd1, 5'd5, 0, 0, 0, 0, 1, 1, 5'd5, 0, 5'd0), C_ADV};
        table_v[4]  = '{mk(5'd0, 5'd0, 1, 0, 0, 0, 1, 1, 5'd0, 0, 5'd0), C_ADV};
        table_v[5]  = '{mk(5'd3, 5'd1, 1, 1, 1, 0, 0, 1, 5'd3, 0, 5'd0), C_STALL};
        table_v[6]  = '{mk(5'd3, 5'd1, 1, 0, 0, 0, 0, 1, 5'd3, 0, 5'd0), C_ADV};
        table_v[7]  = '{mk(5'd1, 5'd4, 1, 1, 0, 0, 0, 0, 5'd0, 1, 5'd4), C_STALL};
        table_v[8]  = '{mk(5'd1, 5'd4, 1, 0, 0, 0, 0, 0, 5'd0, 1, 5'd4), C_ADV};
        table_v[9]  = '{mk(5'd1, 5'd2, 1, 1, 1, 0, 0, 1, 5'd6, 1, 5'd7), C_FLUSH};
        table_v[10] = '{mk(5'd1, 5'd2, 1, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0), C_ADV};
        table_v[11] = '{mk(5'd1, 5'd2, 0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0), C_FLUSH};
        table_v[12] = '{mk(5'd8, 5'd2, 0, 0, 0, 1, 1, 1, 5'd8, 0, 5'd0), C_STALL};
        table_v[13] = '{mk(5'd0, 5'd2, 0, 1, 1, 0, 0, 0, 5'd0, 1, 5'd0), C_FLUSH};

        doReset();

        // Vector table; all entries stay in RUN.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(table_v[i].in);
            checkOutput($sformatf("vec%0d", i), 32'(ctrlOf()), 32'(table_v[i].exp));
            clockEdge();
        end

        // Load-use: lw $2 in EX, add rs=2 in ID, then the bubble reaches EX.
        doReset();
        s = mk(5'd2, 5'd0, 0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0);
        cycle(s, "luStall");
        s = mk(5'd2, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0);
        cycle(s, "luAdvance");
        checkOutput("luStallCount", 32'(Stall_Count), 32'd1);

        // Branch on an ALU result in EX: one stall, then taken flush.
        doReset();
        s = mk(5'd3, 5'd0, 0, 1, 1, 0, 0, 1, 5'd3, 0, 5'd0);
        cycle(s, "beStall");
        s = mk(5'd3, 5'd0, 0, 1, 1, 0, 0, 0, 5'd0, 0, 5'd3);
        cycle(s, "beFlush");
        checkOutput("beStallCount", 32'(Stall_Count), 32'd1);
        checkOutput("beFlushCount", 32'(Flush_Count), 32'd1);

        // Branch on a load in EX: two stalls as the load moves to MEM, then flush.
        doReset();
        s = mk(5'd3, 5'd0, 0, 1, 1, 0, 1, 1, 5'd3, 0, 5'd0);
        cycle(s, "blStall1");
        s = mk(5'd3, 5'd0, 0, 1, 1, 0, 0, 0, 5'd0, 1, 5'd3);
        cycle(s, "blStall2");
        s = mk(5'd3, 5'd0, 0, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0);
        cycle(s, "blFlush");
        checkOutput("blStallCount", 32'(Stall_Count), 32'd2);
        checkOutput("blFlushCount", 32'(Flush_Count), 32'd1);

        // MDU issue: start pulse, then exactly LAT frozen cycles with noisy hazard inputs.
        doReset();
        s = idle; s.mdu = 1'b1;
        applyStimulus(s);
        checkOutput("mduStart", 32'(ctrlOf()), 32'(C_START));
        clockEdge();
        for (int i = 0; i < LAT; i++) begin
            s = mk(5'd3, 5'd3, 1, 1, 1, i[0], 1, 1, 5'd3, 1, 5'd3);
            applyStimulus(s);
            checkOutput($sformatf("mduWait%0d", i), 32'(ctrlOf()), 32'(C_WAIT));
            clockEdge();
        end
        applyStimulus(idle);
        checkOutput("mduDone", 32'(ctrlOf()), 32'(C_ADV));
        checkOutput("mduStallCount", 32'(Stall_Count), 32'd4);
        clockEdge();

        // Reset landing on the second MDU wait cycle.
        doReset();
        s = idle; s.mdu = 1'b1;
        cycle(s, "abortStart");
        cycle(idle, "abortWait1");
        doReset();
        cycle(idle, "abortAfter");

        // Latency-1 instance: a single busy cycle.
        doReset();
        s = idle; s.mdu = 1'b1;
        applyStimulus(s);
        checkOutput("lat1Start", 32'(ctrl1Of()), 32'(C_START));
        clockEdge();
        applyStimulus(idle);
        checkOutput("lat1Wait", 32'(ctrl1Of()), 32'(C_WAIT));
        clockEdge();
        applyStimulus(idle);
        checkOutput("lat1Done", 32'(ctrl1Of()), 32'(C_ADV));
        checkOutput("lat1Stall", 32'(stall1), 32'd1);
        checkOutput("lat1Flush", 32'(flush1), 32'd0);
        clockEdge();

        // Counter wrap at 4 bits: 15 stalls reach all-ones, the 16th wraps to zero.
        doReset();
        s = mk(5'd2, 5'd0, 0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0);
        for (int i = 0; i < 15; i++) cycle(s, "wrapStall");
        checkOutput("wrapAllOnes", 32'(Stall_Count), 32'd15);
        cycle(s, "wrapStall");
        checkOutput("wrapZero", 32'(Stall_Count), 32'd0);

        // Randomized traffic against the model, small register numbers to provoke matches.
        doReset();
        for (int i = 0; i < 400; i++) begin
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.usesRt  = 1'($urandom);
            s.br      = 1'($urandom);
            s.taken   = 1'($urandom);
            s.jump    = ($urandom_range(0, 5) == 0);
            s.mdu     = ($urandom_range(0, 9) == 0);
            if (s.mdu) begin
                s.br   = 1'b0;
                s.jump = 1'b0;
            end
            s.exMr    = 1'($urandom);
            s.exRw    = 1'($urandom);
            s.exDest  = 5'($urandom_range(0, 3));
            s.memMr   = 1'($urandom);
            s.memDest = 5'($urandom_range(0, 3));
            cycle(s, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline controller for the five-stage MIPS datapath. It sequences the IF/ID and ID/EX pipeline registers and the PC. It decides each cycle whether to advance, stall with a bubble inserted into ID/EX, or flush IF/ID. It also owns a multi-cycle multiply/divide unit (MDU): it starts the MDU and freezes the front end for the MDU latency. Stall and flush events are counted for performance measurement.

Parameters:
MDU_LATENCY, 4, cycles the front end is frozen after an MDU op issues; legal range 1..255.
CNT_WIDTH, 32, width of the stall and flush event counters.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Rst_n  input  1  asynchronous active-low reset.
IF_ID_rs  input  5  rs field of the instruction in ID.
IF_ID_rt  input  5  rt field of the instruction in ID.
ID_UsesRt  input  1  the ID instruction reads rt as a source.
ID_Branch  input  1  the ID instruction is a conditional branch (compared in ID).
ID_BranchTaken  input  1  the ID branch comparison is true; valid only when ID_Branch=1.
ID_Jump  input  1  the ID instruction is j/jal/jr.
ID_MduOp  input  1  the ID instruction is mult/div class.
ID_EX_MemRead  input  1  the instruction in EX is a load.
ID_EX_RegWrite  input  1  the instruction in EX writes a register.
ID_EX_Dest  input  5  destination register of the instruction in EX.
EX_MEM_MemRead  input  1  the instruction in MEM is a load.
EX_MEM_Dest  input  5  destination register of the instruction in MEM.
PCWrite  output  1  1 = PC updates this cycle.
IF_ID_Write  output  1  1 = IF/ID loads this cycle.
IF_ID_Flush  output  1  1 = IF/ID loads a nop this cycle.
ID_EX_Bubble  output  1  1 = ID/EX control_WB/M/EX load zero this cycle.
Mdu_Start  output  1  one-cycle MDU start pulse.
Mdu_Busy  output  1  1 while in MDU_WAIT.
Stall_Count  output  CNT_WIDTH  cycles with PCWrite=0.
Flush_Count  output  CNT_WIDTH  cycles with IF_ID_Flush=1.

Behaviour:
- Reset (Rst_n=0, asynchronous, any time, including mid-MDU wait):
  - state goes to RUN; wait counter, Stall_Count and Flush_Count go to 0.
  - Outputs during reset: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, Mdu_Start=0, Mdu_Busy=0.
- Source match: srcA = IF_ID_rs; srcB = IF_ID_rt only when ID_UsesRt=1. A destination equal to 0 never matches.
- Hazard conditions, evaluated combinationally in RUN:
  - LU (load-use): ID_EX_MemRead and ID_EX_Dest matches a source.
  - BE (branch on EX result): ID_Branch and ID_EX_RegWrite and ID_EX_Dest matches a source. This covers the EX-load case; the following cycle then raises BM naturally, giving 2 stall cycles in total.
  - BM (branch on MEM load): ID_Branch and EX_MEM_MemRead and EX_MEM_Dest matches a source.
  - STALL = LU | BE | BM.
- Outputs in RUN:
  - STALL: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0. A branch or jump being stalled never flushes.
  - Not STALL, and (ID_Branch & ID_BranchTaken) | ID_Jump: IF_ID_Flush=1, PCWrite=1, IF_ID_Write=1.
  - Not STALL and ID_MduOp: Mdu_Start=1, pipeline advances this cycle; next state MDU_WAIT, counter loaded with MDU_LATENCY-1.
  - MDU op and jump/branch are mutually exclusive opcodes; no tie-break rule is needed.
- MDU_WAIT state:
  - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, Mdu_Busy=1. Hazard and branch inputs are ignored.
  - Counter decrements each cycle; at counter=0 the next state is RUN.
  - The state lasts exactly MDU_LATENCY cycles. MDU_LATENCY=1 gives a single wait cycle.
- Counters:
  - Stall_Count increments on each edge where PCWrite=0 (hazard or MDU).
  - Flush_Count increments on each edge where IF_ID_Flush=1.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- Latency: all control outputs are combinational from state and inputs (zero latency); counters are registered (+1 cycle).

Test Plan:
- Reset, then lw $2 in EX (ID_EX_MemRead=1, Dest=2) with add using rs=2 in ID -> exactly one cycle PCWrite=0 and ID_EX_Bubble=1; Stall_Count=1.
- beq rs=3 in ID, add Dest=3 in EX -> 1 stall cycle, then BranchTaken=1 -> IF_ID_Flush=1 for 1 cycle; Flush_Count=1. Same test with lw Dest=3 in EX -> 2 stall cycles, then flush.
- Dest=0 in EX with MemRead=1 and rs=0 -> no stall; ID_UsesRt=0 with rt match -> no stall.
- ID_MduOp with MDU_LATENCY=4 -> Mdu_Start high 1 cycle; Mdu_Busy and PCWrite=0 for exactly 4 cycles; Stall_Count +4. Branch/hazard inputs toggled during the wait -> no effect.
- Rst_n driven low on the 2nd MDU_WAIT cycle -> immediate RUN, counters 0, PCWrite=1, Mdu_Busy=0.
- Force Stall_Count to all-ones with CNT_WIDTH=4 (15 stalls) plus 1 more stall -> wraps to 0.
